pipe_stage_skid_reg: RTL and testbench

//  Generic pipeline-stage register for the 5-stage RISC-V core, replacing the per-stage hand-written regs (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid_reg.sv | 146 ++++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with a 2-entry skid: 1-cycle latency, full throughput, in_ready is registered (no path from out_ready).
// Optional saturating stall/flush counters are built only when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_skid_reg #(
  parameter int CTRL_WIDTH = 16,
  parameter int DATA_WIDTH = 160,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  stats_clr,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);

  // Encoding is {skid_v, main_v}; 2'b10 would mean a skid entry with no main entry.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t                state, state_n;
  logic                  main_v, skid_v;
  logic [CTRL_WIDTH-1:0] main_c, skid_c;
  logic [DATA_WIDTH-1:0] main_d, skid_d;
  logic                  in_fire, out_fire;
  logic                  load_main_in, load_main_skid, load_skid, clr_all;

  assign main_v    = state[0];
  assign skid_v    = state[1];
  assign in_ready  = ~rst & ~skid_v;
  assign out_valid = main_v;
  assign out_ctrl  = main_v ? main_c : '0;
  assign out_data  = main_d;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clr_all        = 1'b0;
    if (flush) begin
      // Kills everything held and any same-cycle input; a same-cycle out_fire has already been seen downstream.
      state_n = EMPTY;
      clr_all = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_n      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (out_fire) begin
            state_n = EMPTY;
          end else if (in_fire) begin
            state_n   = TWO;
            load_skid = 1'b1;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_n        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_c <= '0;
      main_d <= '0;
      skid_c <= '0;
      skid_d <= '0;
    end else if (clr_all) begin
      main_c <= '0;
      main_d <= '0;
      skid_c <= '0;
      skid_d <= '0;
    end else begin
      if (load_main_in) begin
        main_c <= in_ctrl;
        main_d <= in_data;
      end else if (load_main_skid) begin
        main_c <= skid_c;
        main_d <= skid_d;
        skid_c <= '0;
        skid_d <= '0;
      end
      if (load_skid) begin
        skid_c <= in_ctrl;
        skid_d <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (stats_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && stall_q != '1) stall_q <= stall_q + CNT_WIDTH'(1);
      if (flush && (main_v || skid_v) && flush_q != '1) flush_q <= flush_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign stall_cnt        = '0;
  assign flush_cnt        = '0;
`endif

  a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst) state != 2'b10);

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: vector table plus reset, streaming, stats and flush sequences.
module tb_pipe_stage_skid_reg;
  localparam int CW = 16;
  localparam int DW = 160;
  localparam int NW = 4;
`ifdef PIPE_STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, stats_clr;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int delivered = 0;

  pipe_stage_skid_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stats_clr(stats_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && out_valid && out_ready) delivered++;

  typedef struct {
    logic        iv;
    logic [15:0] ic;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic        erdy;
    logic [15:0] ec;
    logic [31:0] ed;
    logic        cd;
  } vec_t;

  vec_t vt[13];

  function automatic logic [DW-1:0] mkd(input logic [31:0] x);
    return {5{x}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0; stats_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("por_out_valid", out_valid, 0);
    chk("por_out_ctrl", out_ctrl, 0);
    chk("por_out_data", out_data, 0);
    chk("por_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    //        iv  ic        id             ordy fl   ev erdy ec       ed            cd
    vt[0]  = '{1, 16'h0011, 32'hA1A10001, 0,   0,   0, 1,   16'h0,   32'h0,        1};
    vt[1]  = '{1, 16'h0022, 32'hB2B20002, 0,   0,   1, 1,   16'h0011, 32'hA1A10001, 1};
    vt[2]  = '{1, 16'h0033, 32'hC3C30003, 0,   0,   1, 0,   16'h0011, 32'hA1A10001, 1};
    vt[3]  = '{1, 16'h0033, 32'hC3C30003, 1,   0,   1, 0,   16'h0011, 32'hA1A10001, 1};
    vt[4]  = '{1, 16'h0033, 32'hC3C30003, 1,   0,   1, 1,   16'h0022, 32'hB2B20002, 1};
    vt[5]  = '{0, 16'h0000, 32'h00000000, 1,   0,   1, 1,   16'h0033, 32'hC3C30003, 1};
    vt[6]  = '{1, 16'h0044, 32'hD4D40004, 1,   0,   0, 1,   16'h0,   32'h0,        0};
    vt[7]  = '{1, 16'h0055, 32'hE5E50005, 0,   0,   1, 1,   16'h0044, 32'hD4D40004, 1};
    vt[8]  = '{1, 16'h0066, 32'hF6F60006, 0,   1,   1, 0,   16'h0044, 32'hD4D40004, 1};
    vt[9]  = '{1, 16'h0077, 32'h17170007, 0,   0,   0, 1,   16'h0,   32'h0,        1};
    vt[10] = '{1, 16'h0088, 32'h28280008, 1,   1,   1, 1,   16'h0077, 32'h17170007, 1};
    vt[11] = '{0, 16'h0000, 32'h00000000, 1,   0,   0, 1,   16'h0,   32'h0,        1};
    vt[12] = '{0, 16'h0000, 32'h00000000, 1,   0,   0, 1,   16'h0,   32'h0,        1};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].ev);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].erdy);
      chk($sformatf("vec%0d_out_ctrl", i), out_ctrl, vt[i].ec);
      if (vt[i].cd) chk($sformatf("vec%0d_out_data", i), out_data, mkd(vt[i].ed));
      in_valid  = vt[i].iv;
      in_ctrl   = vt[i].ic;
      in_data   = mkd(vt[i].id);
      out_ready = vt[i].ordy;
      flush     = vt[i].fl;
    end
    idle_inputs();

    // Asynchronous reset while two entries are held.
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_ctrl = 16'h0101; in_data = mkd(32'h01010101);
    @(negedge clk);
    in_ctrl = 16'h0202; in_data = mkd(32'h02020202);
    @(negedge clk);
    in_valid = 1'b0;
    chk("two_in_ready", in_ready, 0);
    chk("two_out_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // Back-to-back streaming.
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k > 1) begin
        chk($sformatf("stream%0d_valid", k - 1), out_valid, 1);
        chk($sformatf("stream%0d_ctrl", k - 1), out_ctrl, DW'(k - 1));
        chk($sformatf("stream%0d_data", k - 1), out_data, mkd(32'(k - 1)));
      end
      chk($sformatf("stream%0d_in_ready", k), in_ready, 1);
      in_valid = 1'b1; in_ctrl = 16'(k); in_data = mkd(32'(k));
    end
    @(negedge clk);
    chk("stream8_data", out_data, mkd(32'd8));
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_drained", out_valid, 0);

    // Counters: stall accumulation, clear, saturation, then flush together with out_fire.
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_ctrl = 16'h0a0a; in_data = mkd(32'h0a0a0a0a);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_cnt_5", stall_cnt, STATS ? 5 : 0);
    stats_clr = 1'b1;
    @(negedge clk);
    chk("stall_cnt_clr", stall_cnt, 0);
    stats_clr = 1'b0;
    repeat (20) @(negedge clk);
    chk("stall_cnt_sat", stall_cnt, STATS ? 15 : 0);
    chk("stall_hold_ctrl", out_ctrl, 16'h0a0a);
    chk("stall_hold_data", out_data, mkd(32'h0a0a0a0a));
    d0 = delivered;
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    chk("flushfire_out_valid", out_valid, 0);
    chk("flushfire_in_ready", in_ready, 1);
    chk("flush_cnt_1", flush_cnt, STATS ? 1 : 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_empty_cnt", flush_cnt, STATS ? 1 : 0);
    repeat (2) @(negedge clk);
    chk("flushfire_delivered_once", 32'(delivered - d0), 1);
    chk("flushfire_no_residue", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
